// File: rtl/qstate_reader_if.sv
// Complex amplitude type and the capture/stream bus of the state readout block.
// The reader takes the slave modport; the host/measurement side takes master.
typedef struct packed {
  logic [7:0] a;
  logic [7:0] b;
} complex_num_t;

interface qstate_reader_if #(
  parameter int N = 2
);
  localparam int L = 1 << N;

  logic                   cap_valid;
  logic                   cap_ready;
  complex_num_t [L-1:0]   state;
  logic                   out_valid;
  logic                   out_ready;
  logic [N-1:0]           out_idx;
  logic [7:0]             out_re;
  logic [7:0]             out_im;
  logic [7:0]             out_prob;
  logic                   out_last;
  logic [N+7:0]           out_sum;

  modport master (
    output cap_valid, state, out_ready,
    input  cap_ready, out_valid, out_idx, out_re, out_im, out_prob, out_last, out_sum
  );

  modport slave (
    input  cap_valid, state, out_ready,
    output cap_ready, out_valid, out_idx, out_re, out_im, out_prob, out_last, out_sum
  );
endinterface

// File: rtl/qstate_reader.sv
// Captures a full complex state vector in one handshake and streams it out one
// amplitude per beat, with |a|^2+|b|^2 per beat and the running norm on the last.
module qstate_reader #(
  parameter int N = 2
) (
  input logic            clk,
  input logic            reset,
  qstate_reader_if.slave bus
);
  localparam int L = 1 << N;
  localparam logic [N-1:0] LAST_IDX = N'(L - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } fsm_e;

  fsm_e                 fsm_q, fsm_d;
  complex_num_t [L-1:0] buf_q, buf_d;
  logic [N-1:0]         idx_q, idx_d;
  logic [N+7:0]         acc_q, acc_d;

  logic         cap_ready_s;
  logic         out_valid_s;
  logic         cap_fire_s;
  logic         beat_fire_s;
  logic         last_s;
  complex_num_t cur_s;
  logic [7:0]   prob_s;

  // Sign-magnitude Q1.6 squares summed in Q2.12, truncated to Q2.6, saturated at 0xFF.
  function automatic logic [7:0] prob_of(input logic [6:0] m_a, input logic [6:0] m_b);
    logic [14:0] ext_a;
    logic [14:0] ext_b;
    logic [14:0] p;
    logic [8:0]  scaled;
    ext_a  = {8'd0, m_a};
    ext_b  = {8'd0, m_b};
    p      = (ext_a * ext_a) + (ext_b * ext_b);
    scaled = p[14:6];
    if (scaled[8]) begin
      prob_of = 8'hFF;
    end else begin
      prob_of = scaled[7:0];
    end
  endfunction

  // Control and index/accumulator registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q <= S_IDLE;
      idx_q <= {N{1'b0}};
      acc_q <= {(N+8){1'b0}};
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  // Vector buffer; contents are only meaningful after a capture.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Next-state decode.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: begin
        if (bus.cap_valid) begin
          fsm_d = S_STREAM;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (bus.out_ready && last_s) begin
          fsm_d = S_IDLE;
        end else begin
          fsm_d = S_STREAM;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    cap_ready_s = 1'b0;
    out_valid_s = 1'b0;
    case (fsm_q)
      S_IDLE:   cap_ready_s = 1'b1;
      S_STREAM: out_valid_s = 1'b1;
      default: begin
        cap_ready_s = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Current beat data from the buffer, index and accumulator.
  always_comb begin
    cap_fire_s  = cap_ready_s & bus.cap_valid;
    beat_fire_s = out_valid_s & bus.out_ready;
    last_s      = out_valid_s & (idx_q == LAST_IDX);
    cur_s       = buf_q[idx_q];
    prob_s      = prob_of(cur_s.a[6:0], cur_s.b[6:0]);
  end

  // Capture clears index and accumulator; an accepted beat advances both.
  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    acc_d = acc_q;
    if (cap_fire_s) begin
      buf_d = bus.state;
      idx_d = {N{1'b0}};
      acc_d = {(N+8){1'b0}};
    end else if (beat_fire_s) begin
      idx_d = idx_q + {{(N-1){1'b0}}, 1'b1};
      acc_d = acc_q + {{N{1'b0}}, prob_s};
    end else begin
      buf_d = buf_q;
      idx_d = idx_q;
      acc_d = acc_q;
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.cap_ready = cap_ready_s;
    bus.out_valid = out_valid_s;
    bus.out_idx   = idx_q;
    bus.out_re    = cur_s.a;
    bus.out_im    = cur_s.b;
    bus.out_prob  = prob_s;
    bus.out_last  = last_s;
    bus.out_sum   = acc_q + {{N{1'b0}}, prob_s};
  end
endmodule

// File: tb/tb_qstate_reader.sv
// Directed and randomized bench for qstate_reader against a plain-arithmetic model.
module tb_qstate_reader;
  localparam int N = 2;
  localparam int L = 1 << N;

  typedef complex_num_t [L-1:0] cvec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   obs_prob [L];
  int   obs_sum;

  qstate_reader_if #(.N(N)) bus ();

  qstate_reader #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_prob(input logic [7:0] a, input logic [7:0] b);
    int ma;
    int mb;
    int p;
    ma = int'(a) % 128;
    mb = int'(b) % 128;
    p  = (ma * ma + mb * mb) / 64;
    return (p > 255) ? 255 : p;
  endfunction

  function automatic int model_sum(input cvec_t v);
    int s;
    s = 0;
    for (int i = 0; i < L; i++) s += model_prob(v[i].a, v[i].b);
    return s;
  endfunction

  function automatic cvec_t rand_vec();
    cvec_t v;
    for (int i = 0; i < L; i++) begin
      v[i].a = 8'($urandom);
      v[i].b = 8'($urandom);
    end
    return v;
  endfunction

  task automatic capture(input cvec_t v);
    bus.state     = v;
    bus.cap_valid = 1'b1;
    chk("cap_ready_idle", 32'(bus.cap_ready), 32'd1);
    chk("valid_idle", 32'(bus.out_valid), 32'd0);
    step();
    bus.cap_valid = 1'b0;
  endtask

  // mode 0: ready always high; 1: pattern 1,0,0,1,1,0,1; 2: random.
  // hold: keep cap_valid high and scramble state throughout the stream.
  task automatic stream_vec(input cvec_t v, input int mode, input bit hold);
    bit   pat [7];
    int   exp_idx;
    int   cyc;
    int   p;
    bit   done;
    logic r;
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_idx = 0;
    cyc     = 0;
    done    = 1'b0;
    obs_sum = -1;
    while (!done && cyc < 64) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 7];
        default: r = 1'($urandom_range(0, 1));
      endcase
      p = model_prob(v[exp_idx].a, v[exp_idx].b);
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("cap_ready_stream", 32'(bus.cap_ready), 32'd0);
      chk("out_idx", 32'(bus.out_idx), 32'(exp_idx));
      chk("out_re", 32'(bus.out_re), 32'(v[exp_idx].a));
      chk("out_im", 32'(bus.out_im), 32'(v[exp_idx].b));
      chk("out_prob", 32'(bus.out_prob), 32'(p));
      chk("out_last", 32'(bus.out_last), 32'(exp_idx == L - 1));
      if (exp_idx == L - 1) begin
        chk("out_sum", 32'(bus.out_sum), 32'(model_sum(v)));
        obs_sum = int'(bus.out_sum);
      end
      obs_prob[exp_idx] = int'(bus.out_prob);
      bus.out_ready = r;
      if (hold) begin
        bus.cap_valid = 1'b1;
        bus.state     = rand_vec();
      end
      step();
      if (r) begin
        if (exp_idx == L - 1) done = 1'b1;
        else exp_idx++;
      end
      cyc++;
    end
    if (!done) chk("stream_timeout", 32'd0, 32'd1);
    bus.out_ready = 1'b0;
    chk("valid_after_last", 32'(bus.out_valid), 32'd0);
    chk("cap_ready_after_last", 32'(bus.cap_ready), 32'd1);
  endtask

  initial begin
    cvec_t basic;
    cvec_t v;
    cvec_t v2;

    basic[0] = '{a: 8'h40, b: 8'h00};
    basic[1] = '{a: 8'h20, b: 8'hA0};
    basic[2] = '{a: 8'h80, b: 8'h00};
    basic[3] = '{a: 8'h00, b: 8'hC0};

    reset         = 1'b0;
    bus.cap_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.state     = '0;
    step();
    step();
    reset = 1'b1;
    chk("rst_cap_ready", 32'(bus.cap_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);

    // Reset beats a simultaneous capture request.
    bus.state     = rand_vec();
    bus.cap_valid = 1'b1;
    reset         = 1'b0;
    step();
    reset         = 1'b1;
    bus.cap_valid = 1'b0;
    chk("rst_vs_cap_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_vs_cap_ready", 32'(bus.cap_ready), 32'd1);

    // Basic stream with known probabilities.
    capture(basic);
    stream_vec(basic, 0, 1'b0);
    chk("basic_prob0", 32'(obs_prob[0]), 32'h40);
    chk("basic_prob1", 32'(obs_prob[1]), 32'h20);
    chk("basic_prob2", 32'(obs_prob[2]), 32'h00);
    chk("basic_prob3", 32'(obs_prob[3]), 32'h40);
    chk("basic_sum", 32'(obs_sum), 32'hA0);

    // Saturation, sign bits ignored.
    v = rand_vec();
    v[1] = '{a: 8'h7F, b: 8'hFF};
    v[2] = '{a: 8'hFF, b: 8'h7F};
    capture(v);
    stream_vec(v, 2, 1'b0);
    chk("sat_prob1", 32'(obs_prob[1]), 32'hFF);
    chk("sat_prob2", 32'(obs_prob[2]), 32'hFF);

    // Backpressure: same vector as basic, sum must match the no-stall run.
    capture(basic);
    stream_vec(basic, 1, 1'b0);
    chk("bp_sum", 32'(obs_sum), 32'hA0);

    // Capture isolation; held request is taken one cycle after the last beat.
    v = rand_vec();
    capture(v);
    stream_vec(v, 0, 1'b1);
    v2 = rand_vec();
    capture(v2);
    chk("iso_valid_after_capture", 32'(bus.out_valid), 32'd1);
    stream_vec(v2, 2, 1'b0);

    // Reset in the middle of a stream.
    v = rand_vec();
    capture(v);
    bus.out_ready = 1'b1;
    step();
    step();
    chk("mid_idx_before_reset", 32'(bus.out_idx), 32'd2);
    reset = 1'b0;
    step();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_cap_ready", 32'(bus.cap_ready), 32'd1);
    chk("mid_rst_idx", 32'(bus.out_idx), 32'd0);
    chk("mid_rst_last", 32'(bus.out_last), 32'd0);
    capture(basic);
    stream_vec(basic, 0, 1'b0);
    chk("mid_rst_clean_sum", 32'(obs_sum), 32'hA0);

    // Randomized vectors and backpressure.
    for (int k = 0; k < 8; k++) begin
      v = rand_vec();
      capture(v);
      stream_vec(v, 2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
